output_collector: RTL

Serial-to-parallel collector for the neuron datapath: accepts one DW-bit element per handshake and packs N elements into an N*DW-bit vector. It sits at the output of a layer's serial MAC/neuron unit and presents the packed vector as the next layer's input vector. It is the write-side counterpart of the offset-indexed element selector. Element k occupies bits [k*DW +: DW], the same packing the selector uses, so offset k written here is offset k read there.

---
 rtl/output_collector_pkg.sv | 13 +
 rtl/output_collector_element_write.sv | 20 ++
 rtl/output_collector.sv | 80 ++++++++
 3 files changed

// File: rtl/output_collector_pkg.sv
// Shared definitions for the serial-to-parallel output collector.
// Offset width matches the element selector so offsets index the same lanes.
package output_collector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int OFS_W = 6;

endpackage

// File: rtl/output_collector_element_write.sv
// One-hot decode of the write offset into per-lane write enables.
// This is the write-side mirror of the selector's indexed read.
module output_collector_element_write
  import output_collector_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [OFS_W-1:0] offset,
  input  logic             wr,
  output logic [N-1:0]     lane_we
);

  always_comb begin
    lane_we = '0;
    for (int k = 0; k < N; k++) begin
      lane_we[k] = wr && (offset == OFS_W'(k));
    end
  end

endmodule

// File: rtl/output_collector.sv
// Packs N serially delivered DW-bit elements into one vector, element k at
// [k*DW +: DW], and holds the completed vector until the consumer acks it.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int N      = 10,
  parameter int DW     = 8,
  parameter int DW_VEC = N * DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic [OFS_W-1:0]  offset,
  output logic [DW_VEC-1:0] out_vec,
  output logic              out_valid,
  input  logic              out_ack
);

  state_t         state, state_nxt;
  logic           accept;
  logic           last;
  logic           clear;
  logic [OFS_W:0] ofs_inc;
  logic [N-1:0]   lane_we;

  // A start in FILL wins over a same-cycle element, which is dropped.
  assign accept  = in_valid && (state == FILL) && !start;
  assign ofs_inc = {1'b0, offset} + (OFS_W + 1)'(1);
  assign last    = (ofs_inc == (OFS_W + 1)'(N));
  assign clear   = start && ((state == IDLE) || (state == FILL) ||
                             ((state == FULL) && out_ack));

  output_collector_element_write #(.N(N)) u_element_write (
    .offset  (offset),
    .wr      (accept),
    .lane_we (lane_we)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        if (start)               state_nxt = FILL;
        else if (accept && last) state_nxt = FULL;
      end
      FULL: if (out_ack) state_nxt = start ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    out_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset  <= '0;
      out_vec <= '0;
    end else if (clear) begin
      offset  <= '0;
      out_vec <= '0;
    end else if (accept) begin
      offset <= last ? '0 : ofs_inc[OFS_W-1:0];
      for (int k = 0; k < N; k++) begin
        if (lane_we[k]) out_vec[k*DW +: DW] <= in_data;
      end
    end
  end

endmodule
